// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the 5-stage pipeline: hazard-controller state
// encoding, the canonical NOP instruction loaded on an IF_ID flush, and the
// bundle of pipeline-register control strobes the hazard controller drives.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

  localparam logic [1:0]  ST_RUN      = 2'd0;
  localparam logic [1:0]  ST_MEM_WAIT = 2'd1;
  localparam logic [1:0]  ST_FLUSH    = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;

  typedef enum logic [1:0] {
    S_RUN      = ST_RUN,
    S_MEM_WAIT = ST_MEM_WAIT,
    S_FLUSH    = ST_FLUSH
  } state_t;

  // One strobe per pipeline-register control input.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic ex_mem_hold;
    logic mem_wb_bubble;
  } ctrl_t;

  // Free-running pipeline.
  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
  // Held in reset: nothing advances, every stage is squashed.
  localparam ctrl_t CTRL_RESET   = '{ex_mem_hold: 1'b0, pc_write: 1'b0, if_id_write: 1'b0,
                                     default: 1'b1};
  // Data memory busy: freeze front end and EX/MEM, feed bubbles into WB.
  localparam ctrl_t CTRL_HOLD    = '{ex_mem_hold: 1'b1, mem_wb_bubble: 1'b1, default: 1'b0};
  // Taken branch redirect: PC loads the target, three younger stages die.
  localparam ctrl_t CTRL_REDIR   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                     id_ex_flush: 1'b1, ex_mem_flush: 1'b1, default: 1'b0};
  // Load-use: freeze PC and IF_ID, insert one bubble into EX.
  localparam ctrl_t CTRL_BUBBLE  = '{id_ex_flush: 1'b1, default: 1'b0};
  // Cycle after a redirect: kill the wrong-path instruction now in ID.
  localparam ctrl_t CTRL_SQUASH  = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_flush: 1'b1,
                                     default: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector: the instruction in EX is a load
// whose destination (non-x0) is a source of the instruction in ID.
// Ports:
//   i_id_rs1, i_id_rs2 : source registers of the ID instruction
//   i_ex_rd            : destination register of the EX instruction
//   i_ex_mem_read      : EX instruction is a load
//   o_load_use         : hazard present
// -----------------------------------------------------------------------------
module hazard_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  output logic       o_load_use
);

  assign o_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                      ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Owns every stall and bubble
// decision: load-use bubbles, taken-branch redirects resolved in MEM, and
// multi-cycle data-memory waits (with a timeout that latches err_o).
// Ports:
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   ID_RS1addr_i, ID_RS2addr_i    : sources of the ID instruction
//   EX_RDaddr_i, EX_MemRead_i     : destination / load flag of EX instruction
//   MEM_Branch_i                  : branch in MEM resolved taken
//   MEM_req_i, MEM_ack_i          : data-memory request / completion
//   PC_write_o .. MEM_WB_bubble_o : pipeline-register strobes (combinational)
//   stall_cnt_o                   : saturating count of PC-frozen cycles
//   err_o                         : sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS1addr_i,
  input  logic [4:0]       ID_RS2addr_i,
  input  logic [4:0]       EX_RDaddr_i,
  input  logic             EX_MemRead_i,
  input  logic             MEM_Branch_i,
  input  logic             MEM_req_i,
  input  logic             MEM_ack_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_flush_o,
  output logic             EX_MEM_flush_o,
  output logic             EX_MEM_hold_o,
  output logic             MEM_WB_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic              r_pend_flush;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              r_err;

  state_t w_next_state;
  ctrl_t  w_ctrl;
  logic   w_load_use;
  logic   w_mem_stall;
  logic   w_timeout;
  logic   w_release;

  hazard_detect u_hazard_detect (
    .i_id_rs1      (ID_RS1addr_i),
    .i_id_rs2      (ID_RS2addr_i),
    .i_ex_rd       (EX_RDaddr_i),
    .i_ex_mem_read (EX_MemRead_i),
    .o_load_use    (w_load_use)
  );

  assign w_mem_stall = MEM_req_i && !MEM_ack_i;
  // wait_cnt counts MEM_WAIT cycles from 0, so the MEM_TIMEOUT-th cycle in
  // MEM_WAIT without an ack is treated as the ack and latches err_o.
  assign w_timeout   = (r_state == S_MEM_WAIT) && !MEM_ack_i && (r_wait_cnt == WAIT_LAST);
  assign w_release   = MEM_ack_i || w_timeout;

  // Priority in RUN: memory wait > branch > load-use.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit -- no latches.
    w_ctrl       = CTRL_DEFAULT;
    w_next_state = r_state;
    if (rst_i) begin
      w_ctrl       = CTRL_RESET;
      w_next_state = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            w_ctrl       = CTRL_HOLD;
            w_next_state = S_MEM_WAIT;
          end else if (MEM_Branch_i) begin
            w_ctrl       = CTRL_REDIR;
            w_next_state = S_FLUSH;
          end else if (w_load_use) begin
            w_ctrl       = CTRL_BUBBLE;
          end
        end
        S_MEM_WAIT: begin
          if (!w_release) begin
            w_ctrl = CTRL_HOLD;
          end else if (r_pend_flush) begin
            // Deferred branch redirect lands on the cycle the hold releases.
            w_ctrl       = CTRL_REDIR;
            w_next_state = S_FLUSH;
          end else begin
            w_next_state = S_RUN;
          end
        end
        // Load-use is ignored here: the ID instruction is the one squashed.
        S_FLUSH: begin
          w_ctrl       = CTRL_SQUASH;
          w_next_state = S_RUN;
        end
        default: w_next_state = S_RUN;
      endcase
    end
  end

  // NOTE: every register below resets; none is a memory, so no reset is skipped.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (rst_i) begin
      r_state      <= S_RUN;
      r_pend_flush <= 1'b0;
      r_wait_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (!w_ctrl.pc_write && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            r_pend_flush <= MEM_Branch_i;
            r_wait_cnt   <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (w_release) begin
            r_pend_flush <= 1'b0;
            r_wait_cnt   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign PC_write_o      = w_ctrl.pc_write;
  assign IF_ID_write_o   = w_ctrl.if_id_write;
  assign IF_ID_flush_o   = w_ctrl.if_id_flush;
  assign ID_EX_flush_o   = w_ctrl.id_ex_flush;
  assign EX_MEM_flush_o  = w_ctrl.ex_mem_flush;
  assign EX_MEM_hold_o   = w_ctrl.ex_mem_hold;
  assign MEM_WB_bubble_o = w_ctrl.mem_wb_bubble;
  assign stall_cnt_o     = r_stall_cnt;
  assign err_o           = r_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed stimulus for pipeline_hazard_ctrl. A cycle-level reference model
// (pending memory age, deferred-branch flag, redirect-shadow flag) predicts
// every output each cycle; literal checks in the stimulus pin key values.
// CNT_W is reduced to 5 so counter saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int TB_TIMEOUT = 16;
  localparam int TB_CNT_W   = 5;
  localparam int STALL_MAX  = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic [4:0] ex_rd = '0;
  logic       ex_mr = 1'b0;
  logic       br = 1'b0;
  logic       req = 1'b0;
  logic       ack = 1'b0;

  logic                pc_w, ifid_w, ifid_f, idex_f, exmem_f, exmem_h, memwb_b;
  logic [TB_CNT_W-1:0] stall_cnt;
  logic                err;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ID_RS1addr_i    (rs1),
    .ID_RS2addr_i    (rs2),
    .EX_RDaddr_i     (ex_rd),
    .EX_MemRead_i    (ex_mr),
    .MEM_Branch_i    (br),
    .MEM_req_i       (req),
    .MEM_ack_i       (ack),
    .PC_write_o      (pc_w),
    .IF_ID_write_o   (ifid_w),
    .IF_ID_flush_o   (ifid_f),
    .ID_EX_flush_o   (idex_f),
    .EX_MEM_flush_o  (exmem_f),
    .EX_MEM_hold_o   (exmem_h),
    .MEM_WB_bubble_o (memwb_b),
    .stall_cnt_o     (stall_cnt),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int m_wait_age = -1;   // cycles spent waiting after the request cycle, -1 = none
  bit m_pend     = 1'b0; // branch waiting behind a memory access
  bit m_redirect = 1'b0; // this cycle is the shadow of a redirect
  int m_stall    = 0;
  bit m_err      = 1'b0;

  bit e_pc, e_ifw, e_iff, e_idf, e_exf, e_hold, e_wb;
  bit lu, released, timed_out;

  always @(negedge clk) begin
    lu = ex_mr && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
    {e_pc, e_ifw, e_iff, e_idf, e_exf, e_hold, e_wb} = 7'b1100000;
    released  = 1'b0;
    timed_out = 1'b0;
    if (rst) begin
      {e_pc, e_ifw, e_iff, e_idf, e_exf, e_hold, e_wb} = 7'b0011101;
    end else if (m_redirect) begin
      e_idf = 1'b1;
    end else if (m_wait_age >= 0) begin
      timed_out = !ack && (m_wait_age == TB_TIMEOUT - 1);
      released  = ack || timed_out;
      if (!released) begin
        {e_pc, e_ifw, e_hold, e_wb} = 4'b0011;
      end else if (m_pend) begin
        {e_iff, e_idf, e_exf} = 3'b111;
      end
    end else if (req && !ack) begin
      {e_pc, e_ifw, e_hold, e_wb} = 4'b0011;
    end else if (br) begin
      {e_iff, e_idf, e_exf} = 3'b111;
    end else if (lu) begin
      {e_pc, e_ifw, e_idf} = 3'b001;
    end

    check("pc_write",      pc_w,      e_pc);
    check("if_id_write",   ifid_w,    e_ifw);
    check("if_id_flush",   ifid_f,    e_iff);
    check("id_ex_flush",   idex_f,    e_idf);
    check("ex_mem_flush",  exmem_f,   e_exf);
    check("ex_mem_hold",   exmem_h,   e_hold);
    check("mem_wb_bubble", memwb_b,   e_wb);
    check("stall_cnt",     stall_cnt, m_stall);
    check("err",           err,       m_err);

    // Advance the model to the state after the coming posedge.
    if (rst) begin
      m_wait_age = -1;
      m_pend     = 1'b0;
      m_redirect = 1'b0;
      m_stall    = 0;
      m_err      = 1'b0;
    end else begin
      if (!e_pc && m_stall < STALL_MAX) m_stall++;
      if (m_redirect) begin
        m_redirect = 1'b0;
      end else if (m_wait_age >= 0) begin
        if (released) begin
          if (timed_out) m_err = 1'b1;
          m_redirect = m_pend;
          m_pend     = 1'b0;
          m_wait_age = -1;
        end else begin
          m_wait_age++;
        end
      end else if (req && !ack) begin
        m_wait_age = 0;
        m_pend     = br;
      end else if (br) begin
        m_redirect = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic drive(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] rd, input logic mr, input logic b,
                       input logic rq, input logic ak);
    rst = r; rs1 = s1; rs2 = s2; ex_rd = rd; ex_mr = mr; br = b; req = rq; ack = ak;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset for two cycles.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_rst_pc",     pc_w,    1'b0);
    check("lit_rst_iff",    ifid_f,  1'b1);
    check("lit_rst_idf",    idex_f,  1'b1);
    check("lit_rst_exf",    exmem_f, 1'b1);
    check("lit_rst_wb",     memwb_b, 1'b1);
    check("lit_rst_hold",   exmem_h, 1'b0);
    tick();
    tick();
    check("lit_rst_stall",  stall_cnt, 0);
    check("lit_rst_err",    err,       1'b0);

    // Release: defaults.
    idle();
    check("lit_run_pc",  pc_w,   1'b1);
    check("lit_run_idf", idex_f, 1'b0);
    tick();

    // EX lw x5 / ID add x6,x5,x7 -> one bubble.
    drive(1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lit_lu_pc",  pc_w,   1'b0);
    check("lit_lu_idf", idex_f, 1'b1);
    tick();
    drive(1'b0, 5'd5, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_lu_after_pc", pc_w, 1'b1);
    tick();
    check("lit_lu_stall", stall_cnt, 1);

    // Load to x0: no hazard.
    drive(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lit_x0_pc", pc_w, 1'b1);
    tick();
    // rs2 match.
    drive(1'b0, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lit_rs2_pc", pc_w, 1'b0);
    tick();
    idle();
    tick();
    // Non-load producer: no stall.
    drive(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lit_alu_pc", pc_w, 1'b1);
    tick();
    check("lit_after_lu_stall", stall_cnt, 2);

    // Taken branch in RUN.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lit_br_iff", ifid_f,  1'b1);
    check("lit_br_idf", idex_f,  1'b1);
    check("lit_br_exf", exmem_f, 1'b1);
    check("lit_br_pc",  pc_w,    1'b1);
    tick();
    // FLUSH cycle with a load-use pattern present: ignored.
    drive(1'b0, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lit_fl_idf", idex_f, 1'b1);
    check("lit_fl_pc",  pc_w,   1'b1);
    check("lit_fl_iff", ifid_f, 1'b0);
    tick();
    idle();
    check("lit_fl_done", idex_f, 1'b0);
    tick();
    check("lit_br_stall", stall_cnt, 2);

    // Memory access acked after three stalled cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("lit_mw_hold", exmem_h, 1'b1);
      check("lit_mw_wb",   memwb_b, 1'b1);
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lit_mw_ack_hold", exmem_h, 1'b0);
    check("lit_mw_ack_pc",   pc_w,    1'b1);
    tick();
    check("lit_mw_stall", stall_cnt, 5);
    // Zero-wait access.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lit_zw_pc", pc_w, 1'b1);
    tick();
    idle();
    tick();
    check("lit_zw_stall", stall_cnt, 5);

    // Branch behind a slow memory access: flush deferred to the ack cycle.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("lit_bw_iff",  ifid_f,  1'b0);
      check("lit_bw_hold", exmem_h, 1'b1);
      tick();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("lit_bw_ack_iff", ifid_f,  1'b1);
    check("lit_bw_ack_exf", exmem_f, 1'b1);
    check("lit_bw_ack_pc",  pc_w,    1'b1);
    tick();
    idle();
    check("lit_bw_fl_idf", idex_f, 1'b1);
    tick();
    idle();
    tick();
    check("lit_bw_stall", stall_cnt, 7);

    // No ack: 16 held cycles, released on the next, err latched.
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("lit_to_held", pc_w, 1'b0);
      tick();
    end
    check("lit_to_err_pre", err, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lit_to_release", exmem_h, 1'b0);
    tick();
    check("lit_to_err",   err,       1'b1);
    check("lit_to_stall", stall_cnt, 23);
    idle();
    check("lit_to_run", pc_w, 1'b1);
    tick();
    tick();
    check("lit_to_sticky", err, 1'b1);

    // Reset during a wait with a deferred branch: branch discarded.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("lit_rst2_err",   err,       1'b0);
    check("lit_rst2_stall", stall_cnt, 0);
    idle();
    check("lit_rst2_iff", ifid_f, 1'b0);
    check("lit_rst2_idf", idex_f, 1'b0);
    tick();

    // Reset during FLUSH.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check("lit_rst3_idf", idex_f, 1'b0);
    tick();

    // Continuous load-use: counter saturates.
    for (int i = 0; i < STALL_MAX + 4; i++) begin
      drive(1'b0, 5'd12, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("lit_sat", stall_cnt, STALL_MAX);
    idle();
    tick();
    check("lit_sat_hold", stall_cnt, STALL_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
